// File: rtl/fgen_pkg.sv
// fgen_pkg: shared opcodes, FSM state encoding, status codes and command-word field positions
// for the function-generator sequencer.
package fgen_pkg;

  localparam int CMD_W    = 32;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int ADDR_LSB = 14;
  localparam int DATA_LSB = 0;
  localparam int ARG_LSB  = 0;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_WRITE    = 4'h1;
  localparam logic [3:0] OP_RUN      = 4'h2;
  localparam logic [3:0] OP_STOP     = 4'h3;
  localparam logic [3:0] OP_SET_LEN  = 4'h4;
  localparam logic [3:0] OP_SET_DIV  = 4'h5;
  localparam logic [3:0] OP_RUN_ONCE = 4'h6;
  localparam logic [3:0] OP_CLR_ERR  = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } fgen_state_e;

  localparam logic [7:0] STAT_IDLE  = 8'd1;
  localparam logic [7:0] STAT_WRITE = 8'd2;
  localparam logic [7:0] STAT_RUN   = 8'd3;
  localparam logic [7:0] STAT_ERR   = 8'd4;

  // Draining still counts as playback from the host's point of view.
  function automatic logic [7:0] state_status(input fgen_state_e s);
    case (s)
      ST_WR:            return STAT_WRITE;
      ST_RUN, ST_DRAIN: return STAT_RUN;
      default:          return STAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fgen_sequencer_if.sv
// fgen_sequencer_if: valid/ready command channel carrying 32-bit words from the SPI word assembler.
interface fgen_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;

  modport master (output cmd_valid, output cmd_word, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_word, output cmd_ready);
endinterface

// File: rtl/fgen_rate_div.sv
// fgen_rate_div: playback pacing counter; tick fires once every (divisor+1) enabled cycles.
// The divisor is re-sampled only at a tick or clear, so a new rate starts cleanly on the next interval.
module fgen_rate_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;

  assign tick = en && (cnt_q == div_act_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    if (clr || tick) begin
      cnt_d     = '0;
      div_act_d = div_val;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_act_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
    end
  end

endmodule

// File: rtl/fgen_sequencer.sv
// fgen_sequencer: command decoder, sole owner of the sample-memory port and paced DAC playback engine.
// Build option FGEN_ONESHOT_EN enables opcode 0x6 RUN_ONCE (single pass over 0..len); otherwise 0x6 is illegal.
module fgen_sequencer
  import fgen_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 14,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  fgen_sequencer_if.slave   cmd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dac_en,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              running,
  output logic [7:0]        status,
  output logic              err
);

  fgen_state_e       state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              err_q, err_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_valid_q, dac_valid_d;
  logic              dac_en_q, dac_en_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              running_q, running_d;
  logic [7:0]        status_q, status_d;
`ifdef FGEN_ONESHOT_EN
  logic              oneshot_q, oneshot_d;
`endif

  logic              accept;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              tick;
  logic              div_clr;
  logic              halt_play;
  logic              unused_cmd_bits;

  assign accept          = cmd.cmd_valid && cmd_ready_q;
  assign opcode          = cmd.cmd_word[OPC_MSB:OPC_LSB];
  assign cmd_addr        = cmd.cmd_word[ADDR_LSB +: ADDR_W];
  assign cmd_data        = cmd.cmd_word[DATA_LSB +: DATA_W];
  assign unused_cmd_bits = ^cmd.cmd_word;

  fgen_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == ST_RUN),
    .clr     (div_clr),
    .div_val (div_q),
    .tick    (tick)
  );

  // Restart/stop commands pre-empt a coinciding tick so no stray read is left in flight.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    len_d       = len_q;
    div_d       = div_q;
    err_d       = err_q;
    rd_pend_d   = 1'b0;
    dac_data_d  = dac_data_q;
    dac_valid_d = rd_pend_q;
    dac_en_d    = dac_en_q;
    div_clr     = 1'b0;
    halt_play   = 1'b0;
`ifdef FGEN_ONESHOT_EN
    oneshot_d   = oneshot_q;
`endif

    if (accept) begin
      case (opcode)
        OP_NOP: ;
        OP_WRITE: begin
          if (state_q == ST_IDLE) begin
            state_d     = ST_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = cmd_addr;
            mem_wdata_d = cmd_data;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RUN: begin
          state_d    = ST_RUN;
          mem_addr_d = '0;
          div_clr    = 1'b1;
          halt_play  = 1'b1;
`ifdef FGEN_ONESHOT_EN
          oneshot_d  = 1'b0;
`endif
        end
        OP_STOP: begin
          halt_play = 1'b1;
          if (state_q == ST_RUN) state_d = ST_DRAIN;
        end
        OP_SET_LEN: len_d = cmd.cmd_word[ARG_LSB +: ADDR_W];
        OP_SET_DIV: div_d = cmd.cmd_word[ARG_LSB +: DIV_W];
        OP_CLR_ERR: err_d = 1'b0;
`ifdef FGEN_ONESHOT_EN
        OP_RUN_ONCE: begin
          state_d    = ST_RUN;
          mem_addr_d = '0;
          div_clr    = 1'b1;
          halt_play  = 1'b1;
          oneshot_d  = 1'b1;
        end
`endif
        default: err_d = 1'b1;
      endcase
    end

    if ((state_q == ST_WR) && !mem_we_q) state_d = ST_IDLE;
    if (state_q == ST_WR) state_d = ST_IDLE;

    // Wrap uses >= so a length shrunk below the current address still returns to 0 at the next tick.
    if ((state_q == ST_RUN) && tick && !halt_play) begin
      rd_pend_d  = 1'b1;
      mem_addr_d = (mem_addr_q >= len_q) ? '0 : mem_addr_q + ADDR_W'(1);
`ifdef FGEN_ONESHOT_EN
      if (oneshot_q && (mem_addr_q >= len_q)) state_d = ST_DRAIN;
`endif
    end

    if (rd_pend_q) begin
      dac_data_d = mem_rdata;
      dac_en_d   = 1'b1;
    end

    if ((state_q == ST_DRAIN) && !rd_pend_q && !halt_play) begin
      state_d    = ST_IDLE;
      mem_addr_d = '0;
      dac_en_d   = 1'b0;
    end

    cmd_ready_d = (state_d != ST_WR);
    running_d   = (state_d == ST_RUN);
    status_d    = err_d ? STAT_ERR : state_status(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      len_q       <= '1;
      div_q       <= '0;
      err_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      dac_en_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      running_q   <= 1'b0;
      status_q    <= STAT_IDLE;
`ifdef FGEN_ONESHOT_EN
      oneshot_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      len_q       <= len_d;
      div_q       <= div_d;
      err_q       <= err_d;
      rd_pend_q   <= rd_pend_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      dac_en_q    <= dac_en_d;
      cmd_ready_q <= cmd_ready_d;
      running_q   <= running_d;
      status_q    <= status_d;
`ifdef FGEN_ONESHOT_EN
      oneshot_q   <= oneshot_d;
`endif
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign dac_en        = dac_en_q;
  assign dac_data      = dac_data_q;
  assign dac_valid     = dac_valid_q;
  assign running       = running_q;
  assign status        = status_q;
  assign err           = err_q;

endmodule

// File: tb/tb_fgen_sequencer.sv
// tb_fgen_sequencer: directed scoreboard bench for fgen_sequencer; a negedge monitor pops expected
// memory writes and DAC samples while the stimulus thread pushes them and checks status/timing.
module tb_fgen_sequencer;
  import fgen_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 14;
  localparam int DIV_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fgen_sequencer_if cmdIf();

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              dac_en;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              running;
  logic [7:0]        status;
  logic              err;

  fgen_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmdIf),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dac_en    (dac_en),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .running   (running),
    .status    (status),
    .err       (err)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int nVec = 0;
  int nFail = 0;
  int cyc = 0;
  logic [ADDR_W+DATA_W-1:0] expWr[$];
  logic [DATA_W-1:0]        expDac[$];

  // Synchronous single-port sample memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    logic [ADDR_W+DATA_W-1:0] w;
    logic [DATA_W-1:0]        s;
    if (!rst) begin
      if (mem_we) begin
        nVec++;
        if (expWr.size() == 0) begin
          nFail++;
          $display("[TB] FAIL unexpected_write: addr %0d data %0d, required no write", mem_addr, mem_wdata);
        end else begin
          w = expWr.pop_front();
          if ({mem_addr, mem_wdata} !== w) begin
            nFail++;
            $display("[TB] FAIL mem_write: got addr %0d data %0d, required addr %0d data %0d",
                     mem_addr, mem_wdata, w[ADDR_W+DATA_W-1:DATA_W], w[DATA_W-1:0]);
          end
        end
      end
      if (dac_valid) begin
        nVec++;
        if (expDac.size() == 0) begin
          nFail++;
          $display("[TB] FAIL unexpected_sample: got %0d, required no sample", dac_data);
        end else begin
          s = expDac.pop_front();
          if (dac_data !== s) begin
            nFail++;
            $display("[TB] FAIL dac_sample: got %0d required %0d", dac_data, s);
          end
        end
      end
    end
  end

  function automatic logic [31:0] mkWr(input logic [3:0] op, input logic [7:0] a, input logic [13:0] d);
    return {op, 6'd0, a, d};
  endfunction

  function automatic logic [31:0] mkArg(input logic [3:0] op, input logic [15:0] arg);
    return {op, 12'd0, arg};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nVec++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  // Presents one command, waiting (bounded) for ready; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [31:0] word);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmdIf.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmdIf.cmd_ready) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL cmd_ready_timeout: got 0 required 1");
    end
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_word  = word;
    @(negedge clk);
    cmdIf.cmd_valid = 1'b0;
  endtask

  task automatic waitValid(output int c);
    int k;
    k = 0;
    @(negedge clk);
    while (!dac_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!dac_valid) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL valid_timeout: got no dac_valid in 30 cycles, required one");
    end
    c = cyc;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] wave [4];
    int k, c0, c1, c2, c3, v, nValid;
    wave[0] = 14'd100; wave[1] = 14'd200; wave[2] = 14'd300; wave[3] = 14'd400;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_word  = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_status", status, 1);
    checkOutput("rst_cmd_ready", cmdIf.cmd_ready, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_dac_en", dac_en, 0);
    checkOutput("rst_dac_valid", dac_valid, 0);
    checkOutput("rst_dac_data", dac_data, 0);
    checkOutput("rst_running", running, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      expWr.push_back({8'(i), wave[i]});
      applyStimulus(mkWr(OP_WRITE, 8'(i), wave[i]));
      checkOutput("wr_cmd_ready_low", cmdIf.cmd_ready, 0);
      checkOutput("wr_status", status, 2);
    end

    applyStimulus(mkArg(OP_SET_LEN, 16'd3));
    checkOutput("setlen_idle_status", status, 1);
    applyStimulus(mkArg(OP_SET_DIV, 16'd0));
    for (int i = 0; i < 64; i++) expDac.push_back(wave[i % 4]);
    applyStimulus(mkArg(OP_RUN, 16'd0));
    checkOutput("run_running", running, 1);
    checkOutput("run_status", status, 3);
    checkOutput("run_dac_en_early", dac_en, 0);
    k = 0;
    while (!dac_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("first_valid_latency", k, 2);
    checkOutput("dac_en_on_first", dac_en, 1);

    repeat (5) @(negedge clk);
    applyStimulus(mkArg(OP_SET_DIV, 16'd4));
    waitValid(c0);
    waitValid(c1);
    waitValid(c2);
    waitValid(c3);
    checkOutput("div_next_tick_old_rate", c1 - c0, 1);
    checkOutput("div_period_first", c2 - c1, 5);
    checkOutput("div_period_steady", c3 - c2, 5);

    applyStimulus(mkWr(OP_WRITE, 8'd5, 14'd999));
    checkOutput("run_write_err", err, 1);
    checkOutput("run_write_status", status, 4);
    checkOutput("run_write_running", running, 1);
    waitValid(c0);
    applyStimulus(mkArg(OP_CLR_ERR, 16'd0));
    checkOutput("clr_err_err", err, 0);
    checkOutput("clr_err_status", status, 3);

    waitValid(v);
    repeat (3) @(negedge clk);
    applyStimulus(mkArg(OP_STOP, 16'd0));
    checkOutput("drain_last_sample", dac_valid, 1);
    checkOutput("drain_dac_en", dac_en, 1);
    checkOutput("drain_running", running, 0);
    @(negedge clk);
    checkOutput("stop_dac_en", dac_en, 0);
    checkOutput("stop_dac_valid", dac_valid, 0);
    checkOutput("stop_status", status, 1);
    checkOutput("stop_mem_addr", mem_addr, 0);
    expDac.delete();

    applyStimulus(mkArg(4'hA, 16'd0));
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_status", status, 4);
    applyStimulus(mkArg(OP_CLR_ERR, 16'd0));
    checkOutput("illegal_clr_status", status, 1);

    applyStimulus(mkArg(OP_SET_LEN, 16'd2));
    applyStimulus(mkArg(OP_SET_DIV, 16'd0));
`ifdef FGEN_ONESHOT_EN
    expDac.push_back(14'd100);
    expDac.push_back(14'd200);
    expDac.push_back(14'd300);
    applyStimulus(mkArg(OP_RUN_ONCE, 16'd0));
    checkOutput("once_status", status, 3);
    nValid = 0;
    repeat (15) begin
      @(negedge clk);
      if (dac_valid) nValid++;
    end
    checkOutput("once_valid_count", nValid, 3);
    checkOutput("once_end_status", status, 1);
    checkOutput("once_end_dac_en", dac_en, 0);
`else
    applyStimulus(mkArg(OP_RUN_ONCE, 16'd0));
    checkOutput("op6_err", err, 1);
    checkOutput("op6_status", status, 4);
    checkOutput("op6_running", running, 0);
    repeat (5) @(negedge clk);
    applyStimulus(mkArg(OP_CLR_ERR, 16'd0));
    checkOutput("op6_clr_status", status, 1);
`endif

    expWr.push_back({8'd7, 14'd777});
    applyStimulus(mkWr(OP_WRITE, 8'd7, 14'd777));
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_drops_we", mem_we, 0);
    checkOutput("rst_mid_status", status, 1);
    checkOutput("rst_mid_cmd_ready", cmdIf.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", expWr.size() + expDac.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
